// File: rtl/input_cmd_decoder_pkg.sv
// Shared keypad command codes, operator codes and decoder state encoding.
// Consumers of out_op decode it from the OP_* constants here.
package input_cmd_decoder_pkg;

    localparam int IC_N = 5;

    // NUMd = 1_0ddd(d), OPxx = 0_1ooo (low bits equal the OP_* code), CTOK = 0_0001.
    localparam logic [IC_N-1:0] IC_NONE = 5'h00;
    localparam logic [IC_N-1:0] IC_CTOK = 5'h01;
    localparam logic [IC_N-1:0] IC_OPAD = 5'h08;
    localparam logic [IC_N-1:0] IC_OPSB = 5'h09;
    localparam logic [IC_N-1:0] IC_OPAN = 5'h0A;
    localparam logic [IC_N-1:0] IC_OPOR = 5'h0B;
    localparam logic [IC_N-1:0] IC_OPLS = 5'h0C;
    localparam logic [IC_N-1:0] IC_NUM0 = 5'h10;
    localparam logic [IC_N-1:0] IC_NUM1 = 5'h11;
    localparam logic [IC_N-1:0] IC_NUM2 = 5'h12;
    localparam logic [IC_N-1:0] IC_NUM3 = 5'h13;
    localparam logic [IC_N-1:0] IC_NUM4 = 5'h14;
    localparam logic [IC_N-1:0] IC_NUM5 = 5'h15;
    localparam logic [IC_N-1:0] IC_NUM6 = 5'h16;
    localparam logic [IC_N-1:0] IC_NUM7 = 5'h17;
    localparam logic [IC_N-1:0] IC_NUM8 = 5'h18;
    localparam logic [IC_N-1:0] IC_NUM9 = 5'h19;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_LS  = 3'd4;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_e;

    function automatic logic ic_is_num(input logic [IC_N-1:0] c);
        return c[4] && (c[3:0] <= 4'd9);
    endfunction

    function automatic logic ic_is_op(input logic [IC_N-1:0] c);
        return (c[4:3] == 2'b01) && (c[2:0] <= OP_LS);
    endfunction

endpackage

// File: rtl/input_cmd_decoder_if.sv
// Command input and request/display outputs of the keypad command decoder.
// master = decoder side, slave = keypad encoder / datapath side.
interface input_cmd_decoder_if #(
    parameter int unsigned W = 16
) ();
    import input_cmd_decoder_pkg::*;

    logic [IC_N-1:0] cmd;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_a;
    logic [W-1:0]    out_b;
    logic [2:0]      out_op;
    logic [W-1:0]    disp_val;
    logic            entering_b;
    logic            ovf;

    modport master (
        input  cmd, out_ready,
        output out_valid, out_a, out_b, out_op, disp_val, entering_b, ovf
    );

    modport slave (
        output cmd, out_ready,
        input  out_valid, out_a, out_b, out_op, disp_val, entering_b, ovf
    );

endinterface

// File: rtl/input_bcd_acc.sv
// Decimal operand accumulator: acc = acc*10 + d with digit-count and range limits.
// A rejected digit leaves acc untouched and raises o_ovf for one cycle.
module input_bcd_acc #(
    parameter int unsigned W          = 16,
    parameter int unsigned MAX_DIGITS = 5,
    parameter int unsigned NDW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_digit_en,
    input  logic [3:0]     i_digit,
    output logic [W-1:0]   o_acc,
    output logic [NDW-1:0] o_ndig,
    output logic           o_ovf
);

    logic [W-1:0]   r_acc;
    logic [NDW-1:0] r_ndig;
    logic           r_ovf;

    logic [W+3:0] w_acc_ext;
    logic [W+3:0] w_nxt;
    logic         w_reject;
    logic         w_lead_zero;

    assign w_acc_ext   = {4'b0000, r_acc};
    assign w_nxt       = (w_acc_ext << 3) + (w_acc_ext << 1) + {{W{1'b0}}, i_digit};
    assign w_reject    = (r_ndig == NDW'(MAX_DIGITS)) || (w_nxt[W+3:W] != 4'd0);
    assign w_lead_zero = (r_acc == '0) && (i_digit == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_ndig <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (i_clr) begin
                r_acc  <= '0;
                r_ndig <= '0;
            end else if (i_digit_en) begin
                if (w_reject) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_nxt[W-1:0];
                    // Leading zeros do not use up the digit budget.
                    if (!w_lead_zero) begin
                        r_ndig <= r_ndig + NDW'(1);
                    end
                end
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_ndig = r_ndig;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/input_cmd_decoder.sv
// Keypad command decoder: builds an (A op B) request from digit/operator/CTOK codes
// and hands it to the datapath over a valid/ready handshake.
module input_cmd_decoder
    import input_cmd_decoder_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    input_cmd_decoder_if.master bus
);

    localparam int unsigned NDW = $clog2(MAX_DIGITS + 1);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [W-1:0] r_out_a;
    logic [W-1:0] w_out_a_nxt;
    logic [W-1:0] r_out_b;
    logic [W-1:0] w_out_b_nxt;
    logic [2:0]   r_out_op;
    logic [2:0]   w_out_op_nxt;
    logic         r_out_valid;
    logic         w_out_valid_nxt;

    logic           w_is_num;
    logic           w_is_op;
    logic           w_is_ok;
    logic           w_clr;
    logic           w_digit_en;
    logic [W-1:0]   w_acc;
    logic [NDW-1:0] w_ndig;
    logic           w_ovf;

    assign w_is_num = ic_is_num(bus.cmd);
    assign w_is_op  = ic_is_op(bus.cmd);
    assign w_is_ok  = (bus.cmd == IC_CTOK);

    input_bcd_acc #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS),
        .NDW        (NDW)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_digit_en (w_digit_en),
        .i_digit    (bus.cmd[3:0]),
        .o_acc      (w_acc),
        .o_ndig     (w_ndig),
        .o_ovf      (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_A;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_op    <= OP_ADD;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_a     <= w_out_a_nxt;
            r_out_b     <= w_out_b_nxt;
            r_out_op    <= w_out_op_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_a_nxt     = r_out_a;
        w_out_b_nxt     = r_out_b;
        w_out_op_nxt    = r_out_op;
        w_out_valid_nxt = r_out_valid;
        w_clr           = 1'b0;
        w_digit_en      = 1'b0;
        unique case (r_state)
            S_A: begin
                w_digit_en = w_is_num;
                if (w_is_op) begin
                    w_out_a_nxt  = w_acc;
                    w_out_op_nxt = bus.cmd[2:0];
                    w_clr        = 1'b1;
                    w_state_nxt  = S_B;
                end
            end
            S_B: begin
                w_digit_en = w_is_num;
                // The operator may still be changed until B's first significant digit.
                if (w_is_op && (w_ndig == '0)) begin
                    w_out_op_nxt = bus.cmd[2:0];
                end
                if (w_is_ok) begin
                    w_out_b_nxt     = w_acc;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end
            end
            S_OUT: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_clr           = 1'b1;
                    w_state_nxt     = S_A;
                end
            end
            default: begin
                w_state_nxt = S_A;
            end
        endcase
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_a      = r_out_a;
    assign bus.out_b      = r_out_b;
    assign bus.out_op     = r_out_op;
    assign bus.disp_val   = w_acc;
    assign bus.entering_b = (r_state == S_B);
    assign bus.ovf        = w_ovf;

endmodule

// File: tb/tb_input_cmd_decoder.sv
// Directed bench for input_cmd_decoder: inputs change and outputs are sampled on negedge.
module tb_input_cmd_decoder;
    import input_cmd_decoder_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    input_cmd_decoder_if #(.W(16)) bus ();

    input_cmd_decoder #(
        .W          (16),
        .MAX_DIGITS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One command per cycle; returns at the negedge where its effect is visible.
    task automatic send(input logic [IC_N-1:0] code);
        bus.cmd = code;
        @(negedge clk);
        bus.cmd = IC_NONE;
    endtask

    task automatic finish_req();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        send(IC_NUM3);
        send(IC_OPOR);
        send(IC_NUM4);
        checks++;
        if (bus.out_a !== 16'd3 || bus.entering_b !== 1'b1 || bus.disp_val !== 16'd4) begin
            failures++;
            $display("FAIL reset_pre a=%0d eb=%0b disp=%0d exp a=3 eb=1 disp=4",
                     bus.out_a, bus.entering_b, bus.disp_val);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_a !== 16'd0 || bus.out_b !== 16'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs a=%0d b=%0d v=%0b exp 0 0 0",
                     bus.out_a, bus.out_b, bus.out_valid);
        end
        checks++;
        if (bus.out_op !== OP_ADD || bus.disp_val !== 16'd0 || bus.entering_b !== 1'b0
            || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state op=%0d disp=%0d eb=%0b ovf=%0b exp 0 0 0 0",
                     bus.out_op, bus.disp_val, bus.entering_b, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send(IC_NUM1);
        send(IC_NUM2);
        send(IC_OPAD);
        send(IC_NUM3);
        send(IC_NUM4);
        send(IC_CTOK);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_a !== 16'd12 || bus.out_b !== 16'd34
                || bus.out_op !== OP_ADD) begin
                failures++;
                $display("FAIL basic_hold[%0d] v=%0b a=%0d b=%0d op=%0d exp 1 12 34 0",
                         i, bus.out_valid, bus.out_a, bus.out_b, bus.out_op);
            end
            @(negedge clk);
        end
        finish_req();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.disp_val !== 16'd0 || bus.entering_b !== 1'b0) begin
            failures++;
            $display("FAIL basic_after v=%0b disp=%0d eb=%0b exp 0 0 0",
                     bus.out_valid, bus.disp_val, bus.entering_b);
        end
    endtask

    task automatic test_overflow();
        send(IC_NUM6);
        send(IC_NUM5);
        send(IC_NUM5);
        send(IC_NUM3);
        send(IC_NUM5);
        checks++;
        if (bus.disp_val !== 16'd65535 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_max disp=%0d ovf=%0b exp 65535 0", bus.disp_val, bus.ovf);
        end
        send(IC_NUM0);
        checks++;
        if (bus.disp_val !== 16'd65535 || bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_ndig disp=%0d ovf=%0b exp 65535 1", bus.disp_val, bus.ovf);
        end
        @(negedge clk);
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse ovf=%0b exp 0", bus.ovf);
        end
        send(IC_OPAD);
        send(IC_NUM6);
        send(IC_NUM5);
        send(IC_NUM5);
        send(IC_NUM3);
        send(IC_NUM6);
        checks++;
        if (bus.disp_val !== 16'd6553 || bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_range disp=%0d ovf=%0b exp 6553 1", bus.disp_val, bus.ovf);
        end
        send(IC_CTOK);
        checks++;
        if (bus.out_a !== 16'd65535 || bus.out_b !== 16'd6553) begin
            failures++;
            $display("FAIL ovf_req a=%0d b=%0d exp 65535 6553", bus.out_a, bus.out_b);
        end
        finish_req();
    endtask

    task automatic test_op_replace();
        send(IC_NUM7);
        send(IC_OPAD);
        send(IC_OPSB);
        send(IC_NUM2);
        send(IC_OPAN);
        send(IC_CTOK);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_a !== 16'd7 || bus.out_b !== 16'd2
            || bus.out_op !== OP_SUB) begin
            failures++;
            $display("FAIL op_replace v=%0b a=%0d b=%0d op=%0d exp 1 7 2 1",
                     bus.out_valid, bus.out_a, bus.out_b, bus.out_op);
        end
        finish_req();
    endtask

    task automatic test_ignore_and_zeros();
        send(IC_NUM8);
        send(IC_CTOK);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.disp_val !== 16'd8 || bus.entering_b !== 1'b0) begin
            failures++;
            $display("FAIL ctok_in_a v=%0b disp=%0d eb=%0b exp 0 8 0",
                     bus.out_valid, bus.disp_val, bus.entering_b);
        end
        send(IC_OPLS);
        for (int i = 0; i < 6; i++) begin
            send(IC_NUM0);
            checks++;
            if (bus.ovf !== 1'b0 || bus.disp_val !== 16'd0) begin
                failures++;
                $display("FAIL lead_zero[%0d] ovf=%0b disp=%0d exp 0 0",
                         i, bus.ovf, bus.disp_val);
            end
        end
        send(IC_NUM9);
        checks++;
        if (bus.disp_val !== 16'd9 || bus.ovf !== 1'b0 || bus.entering_b !== 1'b1) begin
            failures++;
            $display("FAIL lead_zero_9 disp=%0d ovf=%0b eb=%0b exp 9 0 1",
                     bus.disp_val, bus.ovf, bus.entering_b);
        end
        send(IC_CTOK);
        checks++;
        if (bus.out_a !== 16'd8 || bus.out_b !== 16'd9 || bus.out_op !== OP_LS) begin
            failures++;
            $display("FAIL ls_req a=%0d b=%0d op=%0d exp 8 9 4",
                     bus.out_a, bus.out_b, bus.out_op);
        end
        finish_req();
    endtask

    task automatic test_s_out_ignore();
        send(IC_NUM1);
        send(IC_OPAD);
        send(IC_NUM9);
        send(IC_CTOK);
        send(IC_NUM5);
        send(IC_OPOR);
        send(IC_CTOK);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_a !== 16'd1 || bus.out_b !== 16'd9
            || bus.out_op !== OP_ADD || bus.disp_val !== 16'd9) begin
            failures++;
            $display("FAIL s_out_hold v=%0b a=%0d b=%0d op=%0d disp=%0d exp 1 1 9 0 9",
                     bus.out_valid, bus.out_a, bus.out_b, bus.out_op, bus.disp_val);
        end
        finish_req();
        send(IC_NUM4);
        checks++;
        if (bus.disp_val !== 16'd4 || bus.entering_b !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_hs disp=%0d eb=%0b v=%0b exp 4 0 0",
                     bus.disp_val, bus.entering_b, bus.out_valid);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.cmd       = IC_NONE;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_op_replace();
        test_ignore_and_zeros();
        test_s_out_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
